// File: rtl/yuv422_to_rgb_if.sv
// Stream bundle for the YUV422-to-RGB preview converter: packed YUV beats in,
// RGB pixels, line envelope and per-line pixel count out.
interface yuv422_to_rgb_if #(
  parameter int PIXEL_PER_CLK = 8,
  parameter int CNT_WIDTH     = 16
);
  logic [PIXEL_PER_CLK*16-1:0] yuv_i;
  logic                        yuv_valid_i;
  logic                        line_valid_i;
  logic [PIXEL_PER_CLK*24-1:0] rgb_o;
  logic                        rgb_valid_o;
  logic                        rgb_line_o;
  logic [CNT_WIDTH-1:0]        pixel_count_o;

  // Source side: drives YUV beats, observes converted pixels.
  modport master (
    output yuv_i, yuv_valid_i, line_valid_i,
    input  rgb_o, rgb_valid_o, rgb_line_o, pixel_count_o
  );

  // Converter side.
  modport slave (
    input  yuv_i, yuv_valid_i, line_valid_i,
    output rgb_o, rgb_valid_o, rgb_line_o, pixel_count_o
  );
endinterface

// File: rtl/yuv422_to_rgb.sv
// Packed YUV422 (V/Y1/U/Y0 per pixel pair) to 8-bit RGB, full-swing integer
// inverse transform in four registered stages, plus an output-aligned line
// envelope and a saturating per-line pixel counter.
module yuv422_to_rgb #(
  parameter int PIXEL_PER_CLK = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  yuv422_to_rgb_if.slave   bus
);
  localparam int PAIRS = PIXEL_PER_CLK / 2;

  logic s1_valid, s2_valid, s3_valid, rgb_valid_q;
  logic [3:0] line_d;

  logic [7:0]        s1_y0 [PAIRS];
  logic [7:0]        s1_y1 [PAIRS];
  logic signed [8:0] s1_u  [PAIRS];
  logic signed [8:0] s1_v  [PAIRS];

  logic [7:0]         s2_y0 [PAIRS];
  logic [7:0]         s2_y1 [PAIRS];
  logic signed [19:0] s2_pr [PAIRS];
  logic signed [19:0] s2_gu [PAIRS];
  logic signed [19:0] s2_gv [PAIRS];
  logic signed [19:0] s2_pb [PAIRS];

  logic [7:0]         s3_y0 [PAIRS];
  logic [7:0]         s3_y1 [PAIRS];
  logic signed [19:0] s3_dr [PAIRS];
  logic signed [19:0] s3_dg [PAIRS];
  logic signed [19:0] s3_db [PAIRS];

  logic [PIXEL_PER_CLK*24-1:0] rgb_q, rgb_next;
  logic                        rgb_line, line_q;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH:0]          cnt_sum;

  function automatic logic [7:0] sat8(input logic signed [19:0] s);
    if (s < 0)               return 8'd0;
    else if (s > 20'sd255)   return 8'hFF;
    else                     return s[7:0];
  endfunction

  function automatic logic [23:0] pix(input logic [7:0] y,
                                      input logic signed [19:0] dr,
                                      input logic signed [19:0] dg,
                                      input logic signed [19:0] db);
    logic signed [19:0] ys;
    ys = $signed({12'd0, y});
    return {sat8(ys + dr), sat8(ys - dg), sat8(ys + db)};
  endfunction

  // Valid bits and the line-delay chain; reset discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      rgb_valid_q <= 1'b0;
      line_d      <= '0;
    end else begin
      s1_valid    <= bus.yuv_valid_i;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      rgb_valid_q <= s3_valid;
      line_d      <= {line_d[2:0], bus.line_valid_i};
    end
  end

  // Datapath stages 1-3: unpack and centre chroma, products, round and shift.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < PAIRS; k++) begin
      s1_v[k]  <= $signed({1'b0, bus.yuv_i[32*k +: 8]}) - 9'sd128;
      s1_y1[k] <= bus.yuv_i[32*k+8 +: 8];
      s1_u[k]  <= $signed({1'b0, bus.yuv_i[32*k+16 +: 8]}) - 9'sd128;
      s1_y0[k] <= bus.yuv_i[32*k+24 +: 8];

      s2_y0[k] <= s1_y0[k];
      s2_y1[k] <= s1_y1[k];
      s2_pr[k] <= 20'(s1_v[k]) * 20'sd359;
      s2_gu[k] <= 20'(s1_u[k]) * 20'sd88;
      s2_gv[k] <= 20'(s1_v[k]) * 20'sd183;
      s2_pb[k] <= 20'(s1_u[k]) * 20'sd454;

      s3_y0[k] <= s2_y0[k];
      s3_y1[k] <= s2_y1[k];
      s3_dr[k] <= (s2_pr[k] + 20'sd128) >>> 8;
      s3_dg[k] <= (s2_gu[k] + s2_gv[k] + 20'sd128) >>> 8;
      s3_db[k] <= (s2_pb[k] + 20'sd128) >>> 8;
    end
  end

  // Stage 4 combinational part: add luma and clamp each channel.
  always_comb begin
    rgb_next = '0;
    for (int k = 0; k < PAIRS; k++) begin
      rgb_next[48*k +: 24]    = pix(s3_y0[k], s3_dr[k], s3_dg[k], s3_db[k]);
      rgb_next[48*k+24 +: 24] = pix(s3_y1[k], s3_dr[k], s3_dg[k], s3_db[k]);
    end
  end

  // Output register holds its last pixels while no beat is emitted.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)    rgb_q <= '0;
    else if (s3_valid) rgb_q <= rgb_next;
  end

  assign rgb_line = line_d[3] | s1_valid | s2_valid | s3_valid | rgb_valid_q;
  assign cnt_sum  = {1'b0, cnt} + (CNT_WIDTH+1)'(PIXEL_PER_CLK);

  // Per-line pixel counter: restart on envelope rise, saturating accumulate.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt    <= '0;
      line_q <= 1'b0;
    end else begin
      line_q <= rgb_line;
      if (rgb_line && !line_q)
        cnt <= rgb_valid_q ? CNT_WIDTH'(PIXEL_PER_CLK) : '0;
      else if (rgb_valid_q)
        cnt <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  assign bus.rgb_o         = rgb_q;
  assign bus.rgb_valid_o   = rgb_valid_q;
  assign bus.rgb_line_o    = rgb_line;
  assign bus.pixel_count_o = cnt;
endmodule
